// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and default widths for the APB requester
package apb_pkg;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_t;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating ACCESS wait counter that flags the last allowed wait cycle
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = (TIMEOUT > 0) ? CW'(TIMEOUT) : '1;
  logic [CW-1:0] r_cnt;
  // count stalled ACCESS cycles, holding at the ceiling instead of wrapping
  always_ff @(posedge pclk)
    if (preset || i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != CMAX) r_cnt <= r_cnt + CW'(1);
  // hit means this stalled edge is the one that would bring the count to TIMEOUT
  assign o_hit = (TIMEOUT != 0) && (r_cnt == CMAX - CW'(1));
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding valid/ready to APB SETUP/ACCESS requester with timeout
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);
  apb_state_t        r_state;
  logic              r_psel, r_penable, r_pwrite, r_rsp_valid, r_rsp_timeout;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata, r_rsp_rdata;
  logic              w_hit, w_done, w_clr, w_en;
  assign cmd_ready = (r_state == ST_IDLE) && !preset;
  assign w_clr     = (r_state == ST_SETUP);
  assign w_en      = (r_state == ST_ACCESS) && !pready;
  assign w_done    = (r_state == ST_ACCESS) && (pready || w_hit);
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .pclk   (pclk),
    .preset (preset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_hit  (w_hit)
  );
  // transfer sequencing; a late pready on the timeout edge still counts as completion
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state       <= ST_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_rsp_valid   <= w_done;
      r_rsp_timeout <= w_done && !pready;
      if (w_done) r_rsp_rdata <= (pready && !r_pwrite) ? prdata : '0;
      unique case (r_state)
        ST_IDLE:
          if (cmd_valid) begin
            r_state  <= ST_SETUP;
            r_psel   <= 1'b1;
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
          end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end
        ST_ACCESS:
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_rdata   = r_rsp_rdata;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized checks of apb_master against a RAM slave and a transfer-level model
module tb_apb_master;
  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_timeout, psel, penable, pwrite, pready;
  logic [31:0] rsp_rdata, pwdata, prdata;
  logic [7:0]  paddr;
  int          n_chk = 0;
  int          n_err = 0;
  int          slv_waits = 0;
  int          acc_w = 0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [int];

  apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  // RAM slave: inserts slv_waits wait states per ACCESS
  assign pready = psel && penable && (acc_w >= slv_waits);
  assign prdata = mem[paddr];
  always @(posedge pclk)
    if (psel && penable) begin
      if (!pready) acc_w <= acc_w + 1;
      else if (pwrite) mem[paddr] <= pwdata;
    end else acc_w <= 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [7:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic do_cmd(input logic w, input logic [7:0] a, input logic [31:0] d, input int waits);
    int n;
    int t;
    logic to;
    slv_waits = waits;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge pclk); t++; end
    chk("ready", cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
    chk("setup", {psel, penable}, 2'b10);
    @(negedge pclk);
    chk("access", {psel, penable, pwrite, paddr, pwdata}, {2'b11, w, a, d});
    n = 2;
    while (n < 40) begin
      @(negedge pclk);
      n++;
      if (rsp_valid) break;
      chk("hold", {psel, penable, pwrite, paddr}, {2'b11, w, a});
    end
    to = (waits >= 16);
    chk("latency", n, 3 + (to ? 15 : waits));
    chk("rsp_to", rsp_timeout, to);
    chk("rdata", rsp_rdata, (w || to) ? 32'h0 : ref_rd(a));
    chk("bus_idle", {psel, penable}, 2'b00);
    if (w && !to) ref_mem[int'(a)] = d;
    @(negedge pclk);
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge pclk);
    chk("rst_bus", {psel, penable, pwrite, paddr, pwdata}, '0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, '0);
    chk("rst_ready", cmd_ready, 0);
    preset = 1'b0;
    #1 chk("ready_after_rst", cmd_ready, 1);

    do_cmd(1'b1, 8'h10, 32'hDEADBEEF, 1);
    do_cmd(1'b0, 8'h10, 32'h0, 2);
    do_cmd(1'b0, 8'h11, 32'h0, 1000);
    do_cmd(1'b0, 8'h10, 32'h0, 15);
    do_cmd(1'b1, 8'h12, 32'h12345678, 1000);
    do_cmd(1'b0, 8'h12, 32'h0, 0);

    begin
      int k, t, last, low_run, nacc;
      logic acc, saw;
      k = 0; t = 0; last = -1; low_run = 0; nacc = 0; saw = 1'b0;
      slv_waits = 0;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = $urandom;
      while (k < 4 && t < 40) begin
        acc = cmd_valid && cmd_ready;
        @(negedge pclk);
        t++;
        if (acc) begin
          ref_mem[int'(cmd_addr)] = cmd_wdata;
          nacc++;
          cmd_addr = cmd_addr + 8'd1;
          cmd_wdata = $urandom;
          if (nacc == 4) cmd_valid = 1'b0;
        end
        if (rsp_valid) begin
          if (last >= 0) chk("b2b_gap", t - last, 3);
          chk("b2b_to", {rsp_timeout, rsp_rdata}, '0);
          last = t;
          k++;
        end
        if (!psel) low_run++;
        else begin
          if (saw && low_run > 0) chk("psel_gap", low_run, 1);
          low_run = 0;
          saw = 1'b1;
        end
      end
      chk("b2b_count", k, 4);
    end
    for (int i = 0; i < 4; i++) do_cmd(1'b0, 8'h40 + 8'(i), 32'h0, 0);

    begin
      int t;
      slv_waits = 1000;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
      t = 0;
      while (!cmd_ready && t < 20) begin @(negedge pclk); t++; end
      @(negedge pclk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge pclk);
      chk("pre_rst_access", {psel, penable}, 2'b11);
      preset = 1'b1;
      @(negedge pclk);
      chk("mid_rst", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
      preset = 1'b0;
      #1 chk("mid_rst_ready", cmd_ready, 1);
      for (int i = 0; i < 4; i++) begin
        @(negedge pclk);
        chk("no_rsp_after_rst", {rsp_valid, psel}, 2'b00);
      end
    end
    do_cmd(1'b0, 8'h10, 32'h0, 2);

    for (int i = 0; i < 24; i++) begin
      int r;
      int waits;
      r = int'($urandom_range(0, 7));
      waits = (r < 5) ? r : (r == 5) ? 15 : (r == 6) ? 16 : 1000;
      do_cmd(1'($urandom), 8'h10 + 8'($urandom_range(0, 3)), $urandom, waits);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
